// File: rtl/source_pkg.sv
// Shared types for the operand-source stage: state encoding, default widths,
// the channel entry layout and a saturating counter helper.
package source_pkg;

  localparam int unsigned SRC_XLEN   = 64;
  localparam int unsigned SRC_PREG_W = 6;
  localparam int unsigned SRC_CTL_W  = 32;
  localparam int unsigned CNT_W      = 32;

  typedef logic [SRC_PREG_W-1:0] preg_addr_t;
  typedef logic [SRC_XLEN-1:0]   word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } src_state_e;

  // Channel entry at the default widths.
  typedef struct packed {
    src_state_e             state;
    logic                   rslv1;
    logic                   rslv2;
    preg_addr_t             psrc1;
    preg_addr_t             psrc2;
    word_t                  d1;
    word_t                  d2;
    logic [SRC_CTL_W-1:0]   payload;
  } src_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/source_operand_snoop.sv
// Combinational matcher of one operand tag against all bypass buses;
// the lowest-index matching bus supplies the data.
module source_operand_snoop #(
  parameter int unsigned NBYP   = 4,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned PREG_W = 6
) (
  input  logic [PREG_W-1:0]      tag,
  input  logic [NBYP-1:0]        byp_valid,
  input  logic [NBYP*PREG_W-1:0] byp_dst,
  input  logic [NBYP*XLEN-1:0]   byp_data,
  output logic                   hit_c,
  output logic [XLEN-1:0]        data_c
);

  // Scan from the top so the lowest matching index is the last writer.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int i = int'(NBYP) - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_dst[i*PREG_W +: PREG_W] == tag)) begin
        hit_c  = 1'b1;
        data_c = byp_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/source_stage_buf.sv
// Operand-source stage: one instruction per channel, operands resolved from the
// regfile or bypass buses, then handed downstream with valid/ready.
// Optional per-channel perf counters under `define SOURCE_STAGE_PERF_EN.
// Regfile ports: operand 1 of channel c at slot 2c, operand 2 at slot 2c+1.
module source_stage_buf
  import source_pkg::*;
#(
  parameter int unsigned NCH    = 8,
  parameter int unsigned NBYP   = 4,
  parameter int unsigned XLEN   = SRC_XLEN,
  parameter int unsigned PREG_W = SRC_PREG_W,
  parameter int unsigned CTL_W  = SRC_CTL_W
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  input  logic [NCH*PREG_W-1:0]     in_psrc1,
  input  logic [NCH*PREG_W-1:0]     in_psrc2,
  input  logic [NCH-1:0]            in_rdy1,
  input  logic [NCH-1:0]            in_rdy2,
  input  logic [NCH*CTL_W-1:0]      in_payload,
  output logic [2*NCH*PREG_W-1:0]   rf_raddr,
  input  logic [2*NCH*XLEN-1:0]     rf_rdata,
  input  logic [NBYP-1:0]           byp_valid,
  input  logic [NBYP*PREG_W-1:0]    byp_dst,
  input  logic [NBYP*XLEN-1:0]      byp_data,
  output logic [NCH-1:0]            out_valid,
  input  logic [NCH-1:0]            out_ready,
  output logic [NCH*XLEN-1:0]       out_d1,
  output logic [NCH*XLEN-1:0]       out_d2,
  output logic [NCH*CTL_W-1:0]      out_payload
`ifdef SOURCE_STAGE_PERF_EN
  ,
  output logic [NCH*CNT_W-1:0]      perf_wait_cycles,
  output logic [NCH*CNT_W-1:0]      perf_stall_cycles
`endif
);

  typedef struct packed {
    src_state_e          state;
    logic                rslv1;
    logic                rslv2;
    logic [PREG_W-1:0]   psrc1;
    logic [PREG_W-1:0]   psrc2;
    logic [XLEN-1:0]     d1;
    logic [XLEN-1:0]     d2;
    logic [CTL_W-1:0]    payload;
  } chan_t;

  for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
    chan_t             ent_q;
    chan_t             ent_d;
    logic              ov_q;
    logic              load;
    logic [PREG_W-1:0] tag1;
    logic [PREG_W-1:0] tag2;
    logic [XLEN-1:0]   rf1;
    logic [XLEN-1:0]   rf2;
    logic              cap1_hit;
    logic              cap2_hit;
    logic              snp1_hit;
    logic              snp2_hit;
    logic [XLEN-1:0]   cap1_data;
    logic [XLEN-1:0]   cap2_data;
    logic [XLEN-1:0]   snp1_data;
    logic [XLEN-1:0]   snp2_data;

    assign tag1 = in_psrc1[c*PREG_W +: PREG_W];
    assign tag2 = in_psrc2[c*PREG_W +: PREG_W];
    assign rf_raddr[(2*c)*PREG_W +: PREG_W]   = tag1;
    assign rf_raddr[(2*c+1)*PREG_W +: PREG_W] = tag2;
    assign rf1 = rf_rdata[(2*c)*XLEN +: XLEN];
    assign rf2 = rf_rdata[(2*c+1)*XLEN +: XLEN];

    assign in_ready[c] = (ent_q.state == EMPTY) || ((ent_q.state == READY) && out_ready[c]);
    assign load        = in_valid[c] && in_ready[c];

    // Capture-time matchers on the incoming tags.
    source_operand_snoop #(.NBYP(NBYP), .XLEN(XLEN), .PREG_W(PREG_W)) u_cap1 (
      .tag(tag1), .byp_valid(byp_valid), .byp_dst(byp_dst), .byp_data(byp_data),
      .hit_c(cap1_hit), .data_c(cap1_data)
    );
    source_operand_snoop #(.NBYP(NBYP), .XLEN(XLEN), .PREG_W(PREG_W)) u_cap2 (
      .tag(tag2), .byp_valid(byp_valid), .byp_dst(byp_dst), .byp_data(byp_data),
      .hit_c(cap2_hit), .data_c(cap2_data)
    );
    // WAIT-state matchers on the held tags.
    source_operand_snoop #(.NBYP(NBYP), .XLEN(XLEN), .PREG_W(PREG_W)) u_snp1 (
      .tag(ent_q.psrc1), .byp_valid(byp_valid), .byp_dst(byp_dst), .byp_data(byp_data),
      .hit_c(snp1_hit), .data_c(snp1_data)
    );
    source_operand_snoop #(.NBYP(NBYP), .XLEN(XLEN), .PREG_W(PREG_W)) u_snp2 (
      .tag(ent_q.psrc2), .byp_valid(byp_valid), .byp_dst(byp_dst), .byp_data(byp_data),
      .hit_c(snp2_hit), .data_c(snp2_data)
    );

    // Next-state: drain/snoop first, a load overrides, flush overrides all.
    always_comb begin
      ent_d = ent_q;
      case (ent_q.state)
        WAIT: begin
          if (!ent_q.rslv1 && snp1_hit) begin
            ent_d.rslv1 = 1'b1;
            ent_d.d1    = snp1_data;
          end
          if (!ent_q.rslv2 && snp2_hit) begin
            ent_d.rslv2 = 1'b1;
            ent_d.d2    = snp2_data;
          end
          ent_d.state = (ent_d.rslv1 && ent_d.rslv2) ? READY : WAIT;
        end
        READY: begin
          if (out_ready[c]) ent_d.state = EMPTY;
        end
        default: ;
      endcase

      if (load) begin
        ent_d.payload = in_payload[c*CTL_W +: CTL_W];
        ent_d.psrc1   = tag1;
        ent_d.psrc2   = tag2;
        ent_d.rslv1   = 1'b1;
        ent_d.rslv2   = 1'b1;
        if (tag1 == '0)       ent_d.d1 = '0;
        else if (cap1_hit)    ent_d.d1 = cap1_data;
        else if (in_rdy1[c])  ent_d.d1 = rf1;
        else begin
          ent_d.d1    = '0;
          ent_d.rslv1 = 1'b0;
        end
        if (tag2 == '0)       ent_d.d2 = '0;
        else if (cap2_hit)    ent_d.d2 = cap2_data;
        else if (in_rdy2[c])  ent_d.d2 = rf2;
        else begin
          ent_d.d2    = '0;
          ent_d.rslv2 = 1'b0;
        end
        ent_d.state = (ent_d.rslv1 && ent_d.rslv2) ? READY : WAIT;
      end

      if (flush) ent_d.state = EMPTY;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        ent_q <= '0;
        ov_q  <= 1'b0;
      end else begin
        ent_q <= ent_d;
        ov_q  <= (ent_d.state == READY);
      end
    end

    assign out_valid[c]                    = ov_q;
    assign out_d1[c*XLEN +: XLEN]          = ent_q.d1;
    assign out_d2[c*XLEN +: XLEN]          = ent_q.d2;
    assign out_payload[c*CTL_W +: CTL_W]   = ent_q.payload;

`ifdef SOURCE_STAGE_PERF_EN
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] stall_q;

    // Occupancy counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wait_q  <= '0;
        stall_q <= '0;
      end else begin
        if (ent_q.state == WAIT) wait_q <= sat_inc(wait_q);
        if ((ent_q.state == READY) && !out_ready[c]) stall_q <= sat_inc(stall_q);
      end
    end

    assign perf_wait_cycles[c*CNT_W +: CNT_W]  = wait_q;
    assign perf_stall_cycles[c*CNT_W +: CNT_W] = stall_q;
`endif
  end

endmodule

// File: tb/tb_source_stage_buf.sv
// Directed bench for source_stage_buf with a per-channel instruction model.
module tb_source_stage_buf;

  localparam int NCH    = 8;
  localparam int NBYP   = 4;
  localparam int XLEN   = 64;
  localparam int PREG_W = 6;
  localparam int CTL_W  = 32;

  logic                    clk;
  logic                    resetn;
  logic                    flush;
  logic [NCH-1:0]          in_valid;
  logic [NCH-1:0]          in_ready;
  logic [NCH*PREG_W-1:0]   in_psrc1;
  logic [NCH*PREG_W-1:0]   in_psrc2;
  logic [NCH-1:0]          in_rdy1;
  logic [NCH-1:0]          in_rdy2;
  logic [NCH*CTL_W-1:0]    in_payload;
  logic [2*NCH*PREG_W-1:0] rf_raddr;
  logic [2*NCH*XLEN-1:0]   rf_rdata;
  logic [NBYP-1:0]         byp_valid;
  logic [NBYP*PREG_W-1:0]  byp_dst;
  logic [NBYP*XLEN-1:0]    byp_data;
  logic [NCH-1:0]          out_valid;
  logic [NCH-1:0]          out_ready;
  logic [NCH*XLEN-1:0]     out_d1;
  logic [NCH*XLEN-1:0]     out_d2;
  logic [NCH*CTL_W-1:0]    out_payload;
`ifdef SOURCE_STAGE_PERF_EN
  logic [NCH*32-1:0]       perf_wait_cycles;
  logic [NCH*32-1:0]       perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  source_stage_buf dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_psrc1(in_psrc1), .in_psrc2(in_psrc2),
    .in_rdy1(in_rdy1), .in_rdy2(in_rdy2), .in_payload(in_payload),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .byp_valid(byp_valid), .byp_dst(byp_dst), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d1(out_d1), .out_d2(out_d2), .out_payload(out_payload)
`ifdef SOURCE_STAGE_PERF_EN
    , .perf_wait_cycles(perf_wait_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference register file contents.
  function automatic logic [63:0] rf_val(input logic [5:0] t);
    return (t == 6'd5) ? 64'hAA : 64'h1000 + 64'(t);
  endfunction

  always_comb begin
    for (int k = 0; k < 2*NCH; k++)
      rf_rdata[k*XLEN +: XLEN] = rf_val(rf_raddr[k*PREG_W +: PREG_W]);
  end

  function automatic void chk(input string nm, input int c, input logic [63:0] got,
                              input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ch%0d got=%0h exp=%0h @%0t", nm, c, got, exp, $time);
    end
  endfunction

  // Model: each channel holds at most one instruction; operands are either known or not.
  typedef struct {
    bit          have;
    bit          valid;
    bit          k1;
    bit          k2;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [31:0] pay;
    int unsigned wcnt;
    int unsigned scnt;
  } m_t;

  m_t m [NCH];

  function automatic void blook(input logic [5:0] t, output bit hit, output logic [63:0] v);
    hit = 0;
    v   = '0;
    for (int i = 0; i < NBYP; i++) begin
      if (!hit && byp_valid[i] && byp_dst[i*PREG_W +: PREG_W] == t) begin
        hit = 1;
        v   = byp_data[i*XLEN +: XLEN];
      end
    end
  endfunction

  function automatic void resolve(input logic [5:0] t, input logic rdy,
                                  output bit k, output logic [63:0] v);
    bit          h;
    logic [63:0] bv;
    blook(t, h, bv);
    if (t == 0)   begin k = 1; v = 64'h0;     end
    else if (h)   begin k = 1; v = bv;        end
    else if (rdy) begin k = 1; v = rf_val(t); end
    else          begin k = 0; v = 64'h0;     end
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NCH; c++) m[c] <= '{default: 0};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_t          n;
        bit          acc;
        bit          h;
        logic [63:0] bv;
        n   = m[c];
        acc = !m[c].have || (m[c].valid && out_ready[c]);
        if (n.have && !n.valid) n.wcnt++;
        if (n.valid && !out_ready[c]) n.scnt++;
        if (flush) begin
          n.have  = 0;
          n.valid = 0;
        end else begin
          if (n.valid && out_ready[c]) begin
            n.have  = 0;
            n.valid = 0;
          end else if (n.have && !n.valid) begin
            if (!n.k1) begin blook(n.p1, h, bv); if (h) begin n.k1 = 1; n.v1 = bv; end end
            if (!n.k2) begin blook(n.p2, h, bv); if (h) begin n.k2 = 1; n.v2 = bv; end end
            n.valid = n.k1 && n.k2;
          end
          if (in_valid[c] && acc) begin
            n.have = 1;
            n.p1   = in_psrc1[c*PREG_W +: PREG_W];
            n.p2   = in_psrc2[c*PREG_W +: PREG_W];
            n.pay  = in_payload[c*CTL_W +: CTL_W];
            resolve(n.p1, in_rdy1[c], n.k1, n.v1);
            resolve(n.p2, in_rdy2[c], n.k2, n.v2);
            n.valid = n.k1 && n.k2;
          end
        end
        m[c] <= n;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      chk("out_valid", c, 64'(out_valid[c]), 64'(m[c].valid));
      chk("in_ready", c, 64'(in_ready[c]), 64'(!m[c].have || (m[c].valid && out_ready[c])));
      chk("rf_raddr1", c, 64'(rf_raddr[(2*c)*PREG_W +: PREG_W]), 64'(in_psrc1[c*PREG_W +: PREG_W]));
      chk("rf_raddr2", c, 64'(rf_raddr[(2*c+1)*PREG_W +: PREG_W]), 64'(in_psrc2[c*PREG_W +: PREG_W]));
      if (m[c].valid) begin
        chk("out_d1", c, out_d1[c*XLEN +: XLEN], m[c].v1);
        chk("out_d2", c, out_d2[c*XLEN +: XLEN], m[c].v2);
        chk("out_payload", c, 64'(out_payload[c*CTL_W +: CTL_W]), 64'(m[c].pay));
      end
`ifdef SOURCE_STAGE_PERF_EN
      chk("perf_wait", c, 64'(perf_wait_cycles[c*32 +: 32]), 64'(m[c].wcnt));
      chk("perf_stall", c, 64'(perf_stall_cycles[c*32 +: 32]), 64'(m[c].scnt));
`endif
    end
  end

  task automatic clr();
    flush     = 1'b0;
    in_valid  = '0;
    in_rdy1   = '0;
    in_rdy2   = '0;
    byp_valid = '0;
  endtask

  task automatic load(input int c, input logic [5:0] p1, input logic [5:0] p2,
                      input logic r1, input logic r2, input logic [31:0] pay);
    in_valid[c]                 = 1'b1;
    in_psrc1[c*PREG_W +: PREG_W] = p1;
    in_psrc2[c*PREG_W +: PREG_W] = p2;
    in_rdy1[c]                  = r1;
    in_rdy2[c]                  = r2;
    in_payload[c*CTL_W +: CTL_W] = pay;
  endtask

  task automatic byp(input int i, input logic [5:0] t, input logic [63:0] d);
    byp_valid[i]              = 1'b1;
    byp_dst[i*PREG_W +: PREG_W] = t;
    byp_data[i*XLEN +: XLEN]    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    in_psrc1   = '0;
    in_psrc2   = '0;
    in_payload = '0;
    byp_dst    = '0;
    byp_data   = '0;
    out_ready  = '1;
    clr();
    @(negedge clk);
    #1;
    chk("rst_out_valid", 0, 64'(out_valid), 64'h0);
    chk("rst_in_ready", 0, 64'(in_ready), 64'hFF);
    chk("rst_out_d1", 0, out_d1[63:0], 64'h0);
    resetn = 1'b1;

    // Ready operands, tag 0 reads as zero.
    load(0, 6'd5, 6'd0, 1'b1, 1'b1, 32'h11);
    tick();
    chk("t1_valid", 0, 64'(out_valid[0]), 64'h1);
    chk("t1_d1", 0, out_d1[0*XLEN +: XLEN], 64'hAA);
    chk("t1_d2", 0, out_d2[0*XLEN +: XLEN], 64'h0);
    chk("t1_pay", 0, 64'(out_payload[0*CTL_W +: CTL_W]), 64'h11);
    clr();
    tick();
    chk("t1_drain", 0, 64'(out_valid[0]), 64'h0);

    // Same-cycle bypass at capture.
    load(2, 6'd9, 6'd3, 1'b0, 1'b1, 32'h22);
    byp(0, 6'd9, 64'h1234);
    tick();
    chk("t2_valid", 2, 64'(out_valid[2]), 64'h1);
    chk("t2_d1", 2, out_d1[2*XLEN +: XLEN], 64'h1234);
    chk("t2_d2", 2, out_d2[2*XLEN +: XLEN], 64'h1003);
    clr();
    tick();

    // WAIT snoop: match arrives three cycles after load.
    load(3, 6'd4, 6'd12, 1'b1, 1'b0, 32'h33);
    tick();
    chk("t3_wait0", 3, 64'(out_valid[3]), 64'h0);
    clr();
    byp(1, 6'd13, 64'h55);
    tick();
    chk("t3_wait1", 3, 64'(out_valid[3]), 64'h0);
    clr();
    tick();
    chk("t3_wait2", 3, 64'(out_valid[3]), 64'h0);
    byp(3, 6'd12, 64'h77);
    tick();
    chk("t3_valid", 3, 64'(out_valid[3]), 64'h1);
    chk("t3_d1", 3, out_d1[3*XLEN +: XLEN], 64'h1004);
    chk("t3_d2", 3, out_d2[3*XLEN +: XLEN], 64'h77);
    clr();
    tick();

    // Backpressure then back-to-back reload.
    out_ready[4] = 1'b0;
    load(4, 6'd7, 6'd8, 1'b1, 1'b1, 32'h44);
    tick();
    chk("t4_valid", 4, 64'(out_valid[4]), 64'h1);
    load(4, 6'd10, 6'd11, 1'b1, 1'b1, 32'h45);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_in_ready_stall", 4, 64'(in_ready[4]), 64'h0);
    end
    chk("t4_hold_d1", 4, out_d1[4*XLEN +: XLEN], 64'h1007);
    chk("t4_hold_pay", 4, 64'(out_payload[4*CTL_W +: CTL_W]), 64'h44);
    out_ready[4] = 1'b1;
    #1;
    chk("t4_in_ready_go", 4, 64'(in_ready[4]), 64'h1);
    tick();
    chk("t4_reload_valid", 4, 64'(out_valid[4]), 64'h1);
    chk("t4_reload_d1", 4, out_d1[4*XLEN +: XLEN], 64'h100A);
    chk("t4_reload_pay", 4, 64'(out_payload[4*CTL_W +: CTL_W]), 64'h45);
    clr();
    tick();
    chk("t4_drain", 4, 64'(out_valid[4]), 64'h0);

    // Flush collides with a load and a drain.
    out_ready[0] = 1'b0;
    load(0, 6'd1, 6'd2, 1'b1, 1'b1, 32'h50);
    load(5, 6'd20, 6'd21, 1'b0, 1'b1, 32'h55);
    tick();
    chk("t5_ch0", 0, 64'(out_valid[0]), 64'h1);
    chk("t5_ch5", 5, 64'(out_valid[5]), 64'h0);
    clr();
    flush = 1'b1;
    load(1, 6'd3, 6'd4, 1'b1, 1'b1, 32'h51);
    out_ready[0] = 1'b1;
    #1;
    chk("t5_in_ready_flush", 1, 64'(in_ready[1]), 64'h1);
    tick();
    chk("t5_flushed", 0, 64'(out_valid), 64'h0);
    clr();
    byp(0, 6'd20, 64'h99);
    tick();
    chk("t5_still_empty", 0, 64'(out_valid), 64'h0);
    clr();

    // Asynchronous reset while one channel waits and another stalls.
    out_ready[7] = 1'b0;
    load(7, 6'd6, 6'd7, 1'b1, 1'b1, 32'h70);
    load(6, 6'd30, 6'd0, 1'b0, 1'b1, 32'h60);
    tick();
    chk("t6_ch7", 7, 64'(out_valid[7]), 64'h1);
    chk("t6_ch6", 6, 64'(out_valid[6]), 64'h0);
    clr();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", 0, 64'(out_valid), 64'h0);
    chk("t6_rst_in_ready", 0, 64'(in_ready), 64'hFF);
    chk("t6_rst_d1", 7, out_d1[7*XLEN +: XLEN], 64'h0);
    @(negedge clk);
    #1;
    resetn = 1'b1;
    out_ready = '1;
    byp(0, 6'd30, 64'h31);
    tick();
    chk("t6_post_valid", 0, 64'(out_valid), 64'h0);
    chk("t6_post_in_ready", 0, 64'(in_ready), 64'hFF);
`ifdef SOURCE_STAGE_PERF_EN
    chk("t6_perf_wait", 6, 64'(perf_wait_cycles[6*32 +: 32]), 64'h0);
    chk("t6_perf_stall", 7, 64'(perf_stall_cycles[7*32 +: 32]), 64'h0);
`endif
    clr();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/source_stage_buf.md
Name: source_stage_buf

Overview:
- Parametrised operand-source stage between issue and the functional units.
- NCH independent channels, each holding one instruction: default 4 ALU + 2 MEM + 1 BR + 1 MUL = 8.
- Reads physical regfile operands at capture. While an operand is still pending, the entry keeps snooping NBYP bypass buses.
- Presents the instruction downstream with valid/ready only once both operands are resolved.

Parameters:
- NCH, 8, number of channels (flat index; FU mapping is the integrator's).
- NBYP, 4, number of writeback/bypass buses.
- XLEN, 64, operand width.
- PREG_W, 6, physical register tag width; tag 0 is hardwired zero.
- CTL_W, 32, opaque width of control+pc+imm payload, passed through unchanged.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all entries
- in_valid  in  NCH  issue request per channel
- in_ready  out  NCH  channel can accept
- in_psrc1, in_psrc2  in  NCH*PREG_W  source tags
- in_rdy1, in_rdy2  in  NCH  operand value available now (RF or bypass)
- in_payload  in  NCH*CTL_W  dst/ctl/pc/imm, opaque
- rf_raddr  out  2*NCH*PREG_W  regfile read tags (combinational from in_psrc*)
- rf_rdata  in  2*NCH*XLEN  regfile data, same cycle
- byp_valid  in  NBYP  bypass bus valid
- byp_dst  in  NBYP*PREG_W  bypass tag
- byp_data  in  NBYP*XLEN  bypass value
- out_valid  out  NCH  instruction ready to execute
- out_ready  in  NCH  FU accepts
- out_d1, out_d2  out  NCH*XLEN  resolved operands
- out_payload  out  NCH*CTL_W  payload

Behaviour:
- Per-channel FSM with states EMPTY, WAIT, READY.
- Reset (async, resetn=0): all channels EMPTY; out_valid=0; out_d*/out_payload=0; in_ready=1 on release.
- in_ready[c] = (state==EMPTY) || (state==READY && out_ready[c]). Combinational, no dependence on in_valid.
- Load: fires when in_valid&in_ready. Captures payload and tags. Each operand value is chosen as:
  - tag 0 → 0;
  - else the lowest-index bypass with byp_valid && byp_dst==tag;
  - else, if in_rdy=1, rf_rdata;
  - else the operand stays pending.
- Next state after load: READY if both operands resolved, else WAIT.
- Latency: load in cycle N → out_valid in cycle N+1 at earliest.
- WAIT: each cycle, each pending operand compares against all bypass buses; on a match, its value is captured and it is marked resolved. When both are resolved, go to READY next cycle. Out_valid=0 in WAIT.
- READY: out_valid=1. Operands are held stable and not re-snooped. On out_ready, go to EMPTY, or load a new instruction the same cycle (back-to-back, one per cycle throughput).
- Bypass priority: lowest index wins when two buses carry the same tag. Bench treats this as illegal but the RTL must remain deterministic.
- Flush: every channel goes to EMPTY next cycle. Flush beats a simultaneous load and a simultaneous out_ready (the FU must ignore out_valid in the flush cycle). in_ready is unaffected in the flush cycle.
- Reset mid-WAIT: entry is discarded, no partial state survives.
- Channels are fully independent; no ordering between channels.

Optional Feature:
- SOURCE_STAGE_PERF_EN. When defined, add output perf_wait_cycles (NCH*32) and perf_stall_cycles (NCH*32), both saturating.
  - perf_wait_cycles increments for each cycle a channel is in WAIT.
  - perf_stall_cycles increments for each cycle with READY && !out_ready.
  - Both clear on reset, not on flush.
- When undefined, the ports and counters are absent and there is zero logic.

Decomposition:
- Package source_pkg: preg_addr_t width, word_t, src_state_e {EMPTY, WAIT, READY}, and a channel entry struct {state, rslv1, rslv2, psrc1, psrc2, d1, d2, payload}.
- Common constants are reused from common.
- Sub-module source_operand_snoop: pure-combinational matcher for one operand against NBYP buses, returning hit and data. It is instanced 2*NCH for capture and 2*NCH for WAIT snooping, sharing the same logic.

Test Plan:
- Ready operands: ch0 load psrc1=5 (rf 0xAA), psrc2=0, rdy=1/1 → cycle+1 out_valid, d1=0xAA, d2=0.
- Capture-bypass: ch2 load psrc1=9, rdy1=0, same-cycle byp0 dst=9 data=0x1234 → READY next cycle, d1=0x1234.
- WAIT snoop: ch3 load psrc2=12, rdy2=0, no bypass; 3 cycles later byp3 dst=12 data=0x77 → out_valid exactly 1 cycle after match, d2=0x77; out_valid=0 before.
- Backpressure/back-to-back: out_ready=0 for 4 cycles with a new in_valid → in_ready=0, outputs stable. Then out_ready=1 → same-cycle reload, next instruction out_valid following cycle.
- Flush collision: in the same cycle, flush=1, in_valid=1 on ch1, out_ready=1 on ch0 → all out_valid=0 next cycle, nothing loaded.
- Async reset mid-WAIT: drop resetn asynchronously → out_valid=0 immediately. After release, in_ready all 1 and perf counters (if enabled) = 0.
